// File: rtl/dispense_req_if.sv
// Request handshake between the vending FSM (master) and the dispense sequencer (slave).
// A transfer happens on a rising edge where req_valid && req_ready; the master holds req_* stable until then.
interface dispense_req_if #(
  parameter int COIN_W = 16
) ();
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_bev;
  logic [COIN_W-1:0] req_change;

  modport master (output req_valid, output req_bev, output req_change, input req_ready);
  modport slave  (input req_valid, input req_bev, input req_change, output req_ready);
endinterface

// File: rtl/dispense_sequencer.sv
// Delivery-stage sequencer: beverage delay, beverage pulse, change delay, one coin per cycle, done.
// Optional macro DISPENSE_ABORT_EN adds abort_in, which cancels the beverage during BEV_WAIT.
module dispense_sequencer #(
  parameter int BEV_DELAY = 10,
  parameter int CHG_DELAY = 20,
  parameter int COIN_W    = 16,
  parameter int COIN_VAL  = 10
) (
  input  logic              clk,
  input  logic              rst,
  dispense_req_if.slave     req,
`ifdef DISPENSE_ABORT_EN
  input  logic              abort_in,
`endif
  output logic [1:0]        bev_out,
  output logic              coin_pulse,
  output logic [COIN_W-1:0] change_out,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              coin_block,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_BEV_WAIT = 3'd1,
    S_BEV_OUT  = 3'd2,
    S_CHG_WAIT = 3'd3,
    S_CHG_PAY  = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  localparam int MAX_D = (BEV_DELAY > CHG_DELAY) ? BEV_DELAY : CHG_DELAY;
  localparam int CNT_W = (MAX_D < 1) ? 1 : $clog2(MAX_D + 1);
  localparam logic [COIN_W-1:0] COIN = COIN_W'(COIN_VAL);

  // Outputs lag the state by one cycle, so the acceptance cycle counts toward the beverage delay.
  localparam logic [CNT_W-1:0] BEV_CNT_INIT = CNT_W'((BEV_DELAY > 1) ? BEV_DELAY - 2 : 0);
  localparam logic [CNT_W-1:0] CHG_CNT_INIT = CNT_W'((CHG_DELAY > 0) ? CHG_DELAY - 1 : 0);
  localparam state_e BEV_ENTRY = (BEV_DELAY > 1) ? S_BEV_WAIT : S_BEV_OUT;
  localparam state_e CHG_ENTRY = (CHG_DELAY > 0) ? S_CHG_WAIT : S_CHG_PAY;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        bev_q, bev_d;
  logic [COIN_W-1:0] remain_q, remain_d;
  logic [COIN_W-1:0] paid_q, paid_d;
  logic              rej_q, rej_d;
  logic              req_ready_q, req_ready_d;
  logic [1:0]        bev_out_q, bev_out_d;
  logic              coin_pulse_q, coin_pulse_d;
  logic [COIN_W-1:0] change_out_q, change_out_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic accept;
  logic bad_req;
  logic abort_w;

`ifdef DISPENSE_ABORT_EN
  assign abort_w = abort_in;
`else
  assign abort_w = 1'b0;
`endif

  assign accept  = req.req_valid && req_ready_q;
  assign bad_req = (req.req_bev == 2'b10) || ((req.req_change % COIN) != '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bev_d    = bev_q;
    remain_d = remain_q;
    paid_d   = paid_q;
    rej_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bad_req) begin
            rej_d = 1'b1;
          end else begin
            bev_d    = req.req_bev;
            remain_d = req.req_change;
            paid_d   = '0;
            if (req.req_bev != 2'b00) begin
              state_d = BEV_ENTRY;
              cnt_d   = BEV_CNT_INIT;
            end else if (req.req_change != '0) begin
              state_d = CHG_ENTRY;
              cnt_d   = CHG_CNT_INIT;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_BEV_WAIT: begin
        if (abort_w) begin
          state_d = (remain_q != '0) ? CHG_ENTRY : S_DONE;
          cnt_d   = CHG_CNT_INIT;
        end else if (cnt_q == '0) begin
          state_d = S_BEV_OUT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_BEV_OUT: begin
        state_d = (remain_q != '0) ? CHG_ENTRY : S_DONE;
        cnt_d   = CHG_CNT_INIT;
      end
      S_CHG_WAIT: begin
        if (cnt_q == '0) state_d = S_CHG_PAY;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_CHG_PAY: begin
        remain_d = remain_q - COIN;
        paid_d   = paid_q + COIN;
        if (remain_q <= COIN) state_d = S_DONE;
      end
      S_DONE: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        bev_d    = 2'b00;
        remain_d = '0;
        paid_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // A good accept drops ready at once; a rejected request leaves the sequencer ready.
    req_ready_d  = (state_q == S_IDLE) && !(accept && !bad_req);
    bev_out_d    = (state_q == S_BEV_OUT) ? bev_q : 2'b00;
    coin_pulse_d = (state_q == S_CHG_PAY);
    done_d       = (state_q == S_DONE);
    change_out_d = (state_q == S_DONE) ? paid_q : '0;
    err_d        = rej_q;
    busy_d       = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bev_q        <= 2'b00;
      remain_q     <= '0;
      paid_q       <= '0;
      rej_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      bev_out_q    <= 2'b00;
      coin_pulse_q <= 1'b0;
      change_out_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bev_q        <= bev_d;
      remain_q     <= remain_d;
      paid_q       <= paid_d;
      rej_q        <= rej_d;
      req_ready_q  <= req_ready_d;
      bev_out_q    <= bev_out_d;
      coin_pulse_q <= coin_pulse_d;
      change_out_q <= change_out_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign req.req_ready = req_ready_q;
  assign bev_out       = bev_out_q;
  assign coin_pulse    = coin_pulse_q;
  assign change_out    = change_out_q;
  assign done          = done_q;
  assign err           = err_q;
  assign busy          = busy_q;
  assign coin_block    = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Scoreboard bench for dispense_sequencer: expected output events are queued at acceptance
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_dispense_sequencer;
  localparam int COIN_W = 16;
  localparam int W      = 52;
  localparam int K_ERR  = 1;
  localparam int K_BEV  = 2;
  localparam int K_COIN = 3;
  localparam int K_DONE = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              abort_in = 1'b0;
  logic [1:0]        bev_out;
  logic              coin_pulse;
  logic [COIN_W-1:0] change_out;
  logic              done, err, busy, coin_block;
  logic [2:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  dispense_req_if #(.COIN_W(COIN_W)) req_if ();

  dispense_sequencer #(
    .BEV_DELAY(10), .CHG_DELAY(20), .COIN_W(COIN_W), .COIN_VAL(10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req_if.slave),
`ifdef DISPENSE_ABORT_EN
    .abort_in  (abort_in),
`endif
    .bev_out   (bev_out),
    .coin_pulse(coin_pulse),
    .change_out(change_out),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .coin_block(coin_block),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers
  function automatic logic [W-1:0] ev(input int c, input int k, input int v);
    return {32'(c), 4'(k), 16'(v)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  // ---------------- driver
  task automatic send(input logic [1:0] bev, input logic [COIN_W-1:0] chg, output int e0);
    int n;
    @(negedge clk);
    req_if.req_valid  = 1'b1;
    req_if.req_bev    = bev;
    req_if.req_change = chg;
    n = 0;
    while (!req_if.req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: req_ready still %0d after %0d cycles, expected 1", req_if.req_ready, n);
    end
    @(posedge clk);
    #1;
    e0 = cyc;
    req_if.req_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitor
  task automatic check_ev(input int k, input int v);
    logic [W-1:0] got, exp;
    checks++;
    got = ev(cyc, k, v);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got cyc=%0d kind=%0d val=%0d, expected no event", cyc, k, v);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp)
        $display("FAIL event: got cyc=%0d kind=%0d val=%0d expected cyc=%0d kind=%0d val=%0d",
                 cyc, k, v, exp[51:20], exp[19:16], exp[15:0]);
      if (got !== exp) errors++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (err)             check_ev(K_ERR, 0);
      if (bev_out != 2'b0) check_ev(K_BEV, int'(bev_out));
      if (coin_pulse)      check_ev(K_COIN, 0);
      if (done)            check_ev(K_DONE, int'(change_out));
      if (!done && change_out != '0)
        chk("change_out_idle", int'(change_out), 0);
      if (coin_block !== busy)
        chk("coin_block_eq_busy", int'(coin_block), int'(busy));
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus
  initial begin
    int e0, e0b;
    req_if.req_valid  = 1'b0;
    req_if.req_bev    = 2'b00;
    req_if.req_change = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    chk("reset_req_ready", int'(req_if.req_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_coin_block", int'(coin_block), 0);
    chk("reset_bev_out", int'(bev_out), 0);
    chk("reset_done", int'(done), 0);

    // beverage only
    send(2'b11, 16'd0, e0);
    exp_q.push_back(ev(e0 + 10, K_BEV, 3));
    exp_q.push_back(ev(e0 + 11, K_DONE, 0));
    wait_cyc(e0);
    chk("bev_only_busy_e0", int'(busy), 0);
    chk("bev_only_ready_e0", int'(req_if.req_ready), 0);
    wait_cyc(e0 + 1);
    chk("bev_only_busy_e1", int'(busy), 1);
    wait_cyc(e0 + 11);
    chk("bev_only_busy_done", int'(busy), 1);
    chk("bev_only_ready_done", int'(req_if.req_ready), 0);
    wait_cyc(e0 + 12);
    chk("bev_only_busy_after", int'(busy), 0);
    chk("bev_only_ready_after", int'(req_if.req_ready), 1);
    drain();

    // beverage plus three coins
    send(2'b01, 16'd30, e0);
    exp_q.push_back(ev(e0 + 10, K_BEV, 1));
    exp_q.push_back(ev(e0 + 31, K_COIN, 0));
    exp_q.push_back(ev(e0 + 32, K_COIN, 0));
    exp_q.push_back(ev(e0 + 33, K_COIN, 0));
    exp_q.push_back(ev(e0 + 34, K_DONE, 30));
    drain();

    // invalid beverage code
    send(2'b10, 16'd0, e0);
    exp_q.push_back(ev(e0 + 1, K_ERR, 0));
    wait_cyc(e0);
    chk("rej_bev_ready_e0", int'(req_if.req_ready), 1);
    wait_cyc(e0 + 1);
    chk("rej_bev_ready_e1", int'(req_if.req_ready), 1);
    chk("rej_bev_busy_e1", int'(busy), 0);
    drain();

    // change not a coin multiple
    send(2'b01, 16'd25, e0);
    exp_q.push_back(ev(e0 + 1, K_ERR, 0));
    drain();

    // second request held during BEV_WAIT
    send(2'b11, 16'd10, e0);
    exp_q.push_back(ev(e0 + 10, K_BEV, 3));
    exp_q.push_back(ev(e0 + 31, K_COIN, 0));
    exp_q.push_back(ev(e0 + 32, K_DONE, 10));
    fork
      send(2'b01, 16'd0, e0b);
      begin
        wait_cyc(e0 + 3);
        chk("hold_ready_bevwait", int'(req_if.req_ready), 0);
        chk("hold_coin_block_bevwait", int'(coin_block), 1);
      end
    join
    chk("hold_second_accept_cycle", e0b, e0 + 34);
    exp_q.push_back(ev(e0b + 10, K_BEV, 1));
    exp_q.push_back(ev(e0b + 11, K_DONE, 0));
    drain();

    // refund only
    send(2'b00, 16'd20, e0);
    exp_q.push_back(ev(e0 + 21, K_COIN, 0));
    exp_q.push_back(ev(e0 + 22, K_COIN, 0));
    exp_q.push_back(ev(e0 + 23, K_DONE, 20));
    drain();

    // nothing to deliver
    send(2'b00, 16'd0, e0);
    exp_q.push_back(ev(e0 + 1, K_DONE, 0));
    drain();

    // reset after two of four coins
    send(2'b00, 16'd40, e0);
    exp_q.push_back(ev(e0 + 21, K_COIN, 0));
    exp_q.push_back(ev(e0 + 22, K_COIN, 0));
    wait_cyc(e0 + 22);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_coin_pulse", int'(coin_pulse), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_req_ready", int'(req_if.req_ready), 1);
    chk("rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_ready_after", int'(req_if.req_ready), 1);
    chk("rst_busy_after", int'(busy), 0);

`ifdef DISPENSE_ABORT_EN
    // abort during BEV_WAIT
    send(2'b11, 16'd20, e0);
    exp_q.push_back(ev(e0 + 27, K_COIN, 0));
    exp_q.push_back(ev(e0 + 28, K_COIN, 0));
    exp_q.push_back(ev(e0 + 29, K_DONE, 20));
    wait_cyc(e0 + 5);
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    drain();
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
